dmem_stream_loader: RTL and testbench
=====================================

// Module: dmem_stream_loader
// PURPOSE
//  Byte-stream DMA engine on the write/read port of the 256x8 data memory.
//  LOAD: accepts a valid/ready byte stream, writes it to consecutive addresses.
//  DUMP: reads consecutive addresses, emits them as a valid/ready byte stream.
//  Owns the memory port only while busy_o=1; the top-level mux hands the port to the core otherwise.
// PARAMETERS
//  ADDR_W  8  memory address width; depth = 2**ADDR_W
//  DATA_W  8  memory/stream data width
// PORTS
//  clk_i        in   1         clock, rising edge
//  rst_ni       in   1         async reset, active low
//  start_i      in   1         start request, sampled in IDLE only
//  mode_i       in   1         0 = LOAD, 1 = DUMP; sampled with start_i
//  base_addr_i  in   ADDR_W    first address; sampled with start_i
//  len_i        in   ADDR_W+1  byte count 0..2**ADDR_W; sampled with start_i
//  abort_i      in   1         synchronous abort of a running transfer
//  busy_o       out  1         transfer in progress (LOAD or DUMP state)
//  done_o       out  1         1-cycle pulse on normal completion
//  s_valid_i    in   1         LOAD stream: byte valid
//  s_data_i     in   DATA_W    LOAD stream: byte
//  s_ready_o    out  1         LOAD stream: ready
//  m_valid_o    out  1         DUMP stream: byte valid
//  m_data_o     out  DATA_W    DUMP stream: byte
//  m_ready_i    in   1         DUMP stream: ready
//  mem_we_o     out  1         memory write enable
//  mem_addr_o   out  ADDR_W    memory address
//  mem_wdata_o  out  DATA_W    memory write data
//  mem_rdata_i  in   DATA_W    memory read data (combinational read)
//  checksum_o   out  DATA_W    only with DMEM_LOADER_CHECKSUM_EN
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=IDLE, ptr=0, cnt=0; all outputs 0.
//  - FSM IDLE->LOAD|DUMP on start_i=1 with len_i!=0: ptr<=base_addr_i, cnt<=len_i.
//  - IDLE->DONE on start_i=1 with len_i==0; no memory access occurs.
//  - start_i while not IDLE: ignored, never queued.
//  - LOAD: s_ready_o=1.
//    mem_we_o = s_valid_i (combinational, same cycle), mem_addr_o=ptr, mem_wdata_o=s_data_i.
//    Each s_valid_i&&s_ready_o handshake: ptr<=ptr+1, cnt<=cnt-1.
//  - DUMP: m_valid_o=1, mem_addr_o=ptr, m_data_o=mem_rdata_i (zero latency); mem_we_o=0.
//    m_data_o is stable while m_valid_o&&!m_ready_i, because ptr holds.
//    Each handshake: ptr++, cnt--.
//  - Handshake with cnt==1 -> DONE. DONE lasts exactly 1 cycle: done_o=1, then IDLE.
//  - busy_o=1 in LOAD/DUMP only. s_ready_o, m_valid_o, mem_we_o are 0 outside their state.
//  - ptr wraps mod 2**ADDR_W (0xFF+1 -> 0x00). len=256 covers the whole memory once.
//  - abort_i in LOAD/DUMP: next state IDLE, no done_o.
//    A handshake in the same cycle still completes: write performed, or byte consumed.
//    Already-written bytes remain. abort_i in IDLE/DONE: no effect.
//  - Reset mid-transfer: immediate return to reset values. Memory contents untouched.
//  - mem_addr_o = ptr in all states; mem_wdata_o = s_data_i always.
// CONFIGURATION
//  - DMEM_LOADER_CHECKSUM_EN defined:
//    checksum_o exists, cleared on an accepted start_i.
//    Adds each transferred byte mod 2**DATA_W; holds value in IDLE.
//  - Not defined: port and logic absent, no other change.
// TESTING
//  - LOAD base=0x10 len=4, bytes A1,B2,C3,D4, s_valid gapped
//    -> mem[0x10..0x13]=A1..D4; 4 writes; done_o 1 cycle after last handshake.
//  - DUMP base=0x10 len=4, m_ready toggled 1,0,0,1...
//    -> m_data A1,B2,C3,D4 in order, stable while stalled; done_o pulses once.
//  - LOAD base=0xFE len=3 -> writes at 0xFE,0xFF,0x00; 0x01 unchanged.
//  - start len=0 -> no mem_we_o, busy_o stays 0, done_o pulses next cycle;
//    start_i while busy -> ignored.
//  - abort_i after 2 of 5 LOAD bytes -> IDLE, 2 bytes written, no done_o;
//    rst_ni low mid-DUMP -> all outputs 0 at once.
//  - CHECKSUM_EN: LOAD 0x80,0x90 -> checksum_o=0x10; new start clears it to 0.

Source files
------------

// File: rtl/dmem_stream_loader.sv
// Byte-stream DMA engine for the data memory port: LOAD writes an incoming stream, DUMP reads one out.
// Optional running checksum output enabled by defining DMEM_LOADER_CHECKSUM_EN.
module dmem_stream_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum_o
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer;

`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]  csum_q, csum_d;
    logic [DATA_W-1:0]  xfer_byte;

    assign xfer_byte  = (state_q == LOAD) ? s_data_i : mem_rdata_i;
    assign checksum_o = csum_q;
`endif

    // A byte moves whenever the active stream side completes a handshake.
    assign xfer = ((state_q == LOAD) && s_valid_i) || ((state_q == DUMP) && m_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
`ifdef DMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef DMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
`ifdef DMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = base_addr_i;
                        cnt_d   = len_i;
                        state_d = mode_i ? DUMP : LOAD;
                    end
                end
            end
            LOAD, DUMP: begin
                if (xfer) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef DMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q + xfer_byte;
`endif
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                // Abort wins over completion; a same-cycle handshake still lands.
                if (abort_i) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = (state_q == LOAD) || (state_q == DUMP);
    assign done_o      = (state_q == DONE);
    assign s_ready_o   = (state_q == LOAD);
    assign m_valid_o   = (state_q == DUMP);
    assign m_data_o    = (state_q == DUMP) ? mem_rdata_i : '0;
    assign mem_we_o    = (state_q == LOAD) && s_valid_i;
    assign mem_addr_o  = ptr_q;
    assign mem_wdata_o = s_data_i;

endmodule

// File: tb/tb_dmem_stream_loader.sv
// Directed self-checking bench for dmem_stream_loader with a behavioural 256x8 memory.
module tb_dmem_stream_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, mode, abort;
    logic [7:0] base;
    logic [8:0] len;
    logic       busy, done;
    logic       s_valid, s_ready;
    logic [7:0] s_data;
    logic       m_valid, m_ready;
    logic [7:0] m_data;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] mem [256];
    logic       clr;
    int         writes = 0;
    int         dones  = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    dmem_stream_loader dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
        .base_addr_i(base), .len_i(len), .abort_i(abort),
        .busy_o(busy), .done_o(done),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
`ifdef DMEM_LOADER_CHECKSUM_EN
        , .checksum_o(checksum)
`endif
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            writes <= writes + 1;
        end
        if (done) dones <= dones + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         w0, d0, idx, cyc;
        logic [7:0] exp_b [4];
        logic       rpat  [4];
        exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rpat  = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; clr = 1'b1; start = 0; mode = 0; abort = 0;
        base = 0; len = 0; s_valid = 1'b1; s_data = 0; m_ready = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_m_data", m_data, 0);
        s_valid = 0;
        rst_n = 1'b1;
        tick();
        clr = 1'b0;
        tick();

        // LOAD 0x10 len 4 with gaps, plus an ignored start while busy
        w0 = writes; d0 = dones;
        start = 1; mode = 0; base = 8'h10; len = 9'd4;
        #1 check("idle_busy", busy, 0);
        tick(); start = 0;
        check("load_busy", busy, 1);
        check("load_ready", s_ready, 1);
        check("load_addr0", mem_addr, 8'h10);
        s_valid = 1; s_data = 8'hA1; tick();
        s_valid = 0; start = 1; mode = 1; base = 8'h80; len = 9'd5;
        #1 check("gap_we", mem_we, 0);
        tick(); start = 0;
        check("ignored_start_addr", mem_addr, 8'h11);
        check("ignored_start_ready", s_ready, 1);
        s_valid = 1; s_data = 8'hB2; tick();
        s_data = 8'hC3; tick();
        s_valid = 0; tick();
        s_valid = 1; s_data = 8'hD4;
        #1 check("last_we", mem_we, 1);
        check("last_addr", mem_addr, 8'h13);
        tick(); s_valid = 0;
        check("load_done", done, 1);
        check("load_done_busy", busy, 0);
        tick();
        check("load_done_clear", done, 0);
        check("load_writes", writes - w0, 4);
        check("load_dones", dones - d0, 1);
        check("mem10", mem[8'h10], 8'hA1);
        check("mem11", mem[8'h11], 8'hB2);
        check("mem12", mem[8'h12], 8'hC3);
        check("mem13", mem[8'h13], 8'hD4);

        // DUMP 0x10 len 4 with back-pressure
        w0 = writes; d0 = dones;
        start = 1; mode = 1; base = 8'h10; len = 9'd4;
        tick(); start = 0;
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 20) begin
            m_ready = rpat[cyc % 4];
            #1;
            check("dump_valid", m_valid, 1);
            check("dump_data", m_data, exp_b[idx]);
            check("dump_we", mem_we, 0);
            if (m_ready) idx++;
            cyc++;
            tick();
        end
        check("dump_bytes", idx, 4);
        m_ready = 0;
        check("dump_done", done, 1);
        check("dump_mvalid_off", m_valid, 0);
        tick();
        check("dump_dones", dones - d0, 1);
        check("dump_writes", writes - w0, 0);

        // LOAD across the address wrap
        start = 1; mode = 0; base = 8'hFE; len = 9'd3;
        tick(); start = 0;
        s_valid = 1; s_data = 8'h11; tick();
        s_data = 8'h22; tick();
        s_data = 8'h33;
        #1 check("wrap_addr", mem_addr, 8'h00);
        tick(); s_valid = 0;
        check("wrap_done", done, 1);
        tick();
        check("memFE", mem[8'hFE], 8'h11);
        check("memFF", mem[8'hFF], 8'h22);
        check("mem00", mem[8'h00], 8'h33);
        check("mem01", mem[8'h01], 8'h00);

        // Zero-length start
        w0 = writes; d0 = dones;
        start = 1; mode = 0; base = 8'h30; len = 9'd0; s_valid = 1; s_data = 8'hEE;
        tick(); start = 0;
        check("len0_busy", busy, 0);
        check("len0_we", mem_we, 0);
        check("len0_done", done, 1);
        tick(); s_valid = 0;
        check("len0_done_clear", done, 0);
        check("len0_writes", writes - w0, 0);
        check("len0_dones", dones - d0, 1);

        // Abort after 2 of 5 LOAD bytes
        w0 = writes; d0 = dones;
        start = 1; mode = 0; base = 8'h40; len = 9'd5;
        tick(); start = 0;
        s_valid = 1; s_data = 8'h5A; tick();
        s_data = 8'h6B; tick();
        s_valid = 0; abort = 1;
        #1 check("abort_busy_before", busy, 1);
        tick(); abort = 0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", s_ready, 0);
        tick();
        check("abort_dones", dones - d0, 0);
        check("abort_writes", writes - w0, 2);
        check("mem40", mem[8'h40], 8'h5A);
        check("mem41", mem[8'h41], 8'h6B);
        check("mem42", mem[8'h42], 8'h00);

`ifdef DMEM_LOADER_CHECKSUM_EN
        // Checksum: 0x80 + 0x90 wraps to 0x10, held in IDLE, cleared by next start
        start = 1; mode = 0; base = 8'h60; len = 9'd2;
        tick(); start = 0;
        s_valid = 1; s_data = 8'h80; tick();
        s_data = 8'h90; tick(); s_valid = 0;
        check("csum_done", checksum, 8'h10);
        tick(); tick();
        check("csum_hold", checksum, 8'h10);
        start = 1; mode = 1; base = 8'h60; len = 9'd1; m_ready = 0;
        tick(); start = 0;
        check("csum_clear", checksum, 8'h00);
        abort = 1; tick(); abort = 0;
`endif

        // Reset in the middle of a DUMP
        start = 1; mode = 1; base = 8'h10; len = 9'd4; m_ready = 0;
        tick(); start = 0;
        check("prerst_mvalid", m_valid, 1);
        check("prerst_data", m_data, 8'hA1);
        rst_n = 1'b0;
        #1;
        check("midrst_mvalid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_mdata", m_data, 0);
        #3 rst_n = 1'b1;
        tick();
        check("postrst_busy", busy, 0);
        check("postrst_mem10", mem[8'h10], 8'hA1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
